// File: rtl/bch_enc_pkg.sv
// Shared BCH constants: field arithmetic and generator polynomial derivation,
// evaluated at elaboration so the encoder and decoder agree on g(x).
package bch_enc_pkg;

  localparam int unsigned M      = 4;
  localparam int unsigned D      = 7;
  localparam int unsigned N      = 15;
  localparam int unsigned IRRPOL = 19;
  localparam int unsigned T      = (D - 1) / 2;
  localparam int unsigned NFULL  = (1 << M) - 1;
  localparam int unsigned GW     = M * T + 1;

  typedef logic [M-1:0]  gf_t;
  typedef logic [GW-1:0] gpoly_t;

  // GF(2^m) multiply, reduction by the primitive polynomial
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t p;
    gf_t aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[M-1] ? (gf_t'(aa << 1) ^ gf_t'(IRRPOL)) : gf_t'(aa << 1);
    end
    return p;
  endfunction

  function automatic gf_t gf_alpha_pow(input int unsigned e);
    gf_t p;
    p = gf_t'(1);
    for (int unsigned i = 0; i < e; i++) p = gf_mul(p, gf_t'(2));
    return p;
  endfunction

  // Minimal polynomial of alpha^i: product of (x + beta) over its conjugacy class
  function automatic logic [M:0] min_poly(input int unsigned i);
    logic [M:0][M-1:0] c;
    logic [M:0]        mp;
    int unsigned       e0;
    int unsigned       e;
    logic              done;
    gf_t               root;
    c    = '0;
    c[0] = gf_t'(1);
    e0   = i % NFULL;
    e    = e0;
    done = 1'b0;
    for (int unsigned k = 0; k < M; k++) begin
      if (!done) begin
        root = gf_alpha_pow(e);
        for (int unsigned j = M; j >= 1; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
        c[0] = gf_mul(c[0], root);
        e    = (e * 2) % NFULL;
        if (e == e0) done = 1'b1;
      end
    end
    for (int unsigned j = 0; j <= M; j++) mp[j] = c[j][0];
    return mp;
  endfunction

  function automatic gpoly_t poly_mul(input gpoly_t a, input logic [M:0] b);
    gpoly_t res;
    res = '0;
    for (int unsigned j = 0; j <= M; j++) begin
      if (b[j]) res = res ^ gpoly_t'(a << j);
    end
    return res;
  endfunction

  // g(x) = LCM of minimal polynomials of alpha^1..alpha^2t (distinct classes only)
  function automatic gpoly_t gen_poly();
    gpoly_t            g;
    logic [NFULL-1:0]  covered;
    int unsigned       e;
    g       = gpoly_t'(1);
    covered = '0;
    for (int unsigned i = 1; i <= 2 * T; i++) begin
      e = i % NFULL;
      if (!covered[e]) begin
        for (int unsigned k = 0; k < M; k++) begin
          covered[e] = 1'b1;
          e          = (e * 2) % NFULL;
        end
        g = poly_mul(g, min_poly(i));
      end
    end
    return g;
  endfunction

  function automatic int unsigned poly_deg(input gpoly_t p);
    int unsigned deg;
    deg = 0;
    for (int unsigned i = 0; i < GW; i++) begin
      if (p[i]) deg = i;
    end
    return deg;
  endfunction

  localparam gpoly_t      G_POLY   = gen_poly();
  localparam int unsigned R        = poly_deg(G_POLY);
  localparam logic [R-1:0] G_LOW   = G_POLY[R-1:0];
  localparam int unsigned DATA_LEN = N - R;
  localparam int unsigned CW       = (R > 1) ? $clog2(R) : 1;

  typedef logic [DATA_LEN-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY
  } state_t;

endpackage

// File: rtl/bch_enc_lfsr.sv
// Galois remainder LFSR: load first bit, shift data in, or shift parity out.
module bch_enc_lfsr #(
  parameter int unsigned  R = 10,
  parameter logic [R-1:0] G = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load,
  input  logic shift_in,
  input  logic shift_out,
  input  logic din,
  output logic msb
);

  logic [R-1:0] lfsr;
  logic [R-1:0] lfsr_nxt;
  logic         fb;

  // Load is a clear followed by a normal shift-in of the first bit
  always_comb begin
    lfsr_nxt = lfsr;
    fb       = 1'b0;
    if (load) begin
      lfsr_nxt = din ? G : '0;
    end else if (shift_in) begin
      fb       = din ^ lfsr[R-1];
      lfsr_nxt = {lfsr[R-2:0], 1'b0} ^ (fb ? G : '0);
    end else if (shift_out) begin
      lfsr_nxt = {lfsr[R-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= '0;
    end else if (ena) begin
      lfsr <= lfsr_nxt;
    end
  end

  assign msb = lfsr[R-1];

endmodule

// File: rtl/bch_enc.sv
// Bit-serial systematic BCH encoder: data passes through, then r parity bits
// of m(x)*x^r mod g(x) follow, framed with sop/val/eop.
module bch_enc
  import bch_enc_pkg::*;
(
  input  logic iclk,
  input  logic ireset,
  input  logic iclkena,
  input  logic isop,
  input  logic ival,
  input  logic ieop,
  input  logic idat,
  output logic ordy,
  output logic osop,
  output logic oval,
  output logic oeop,
  output logic odat
);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ordy_nxt, osop_nxt, oval_nxt, oeop_nxt, odat_nxt;
  logic          lfsr_load, lfsr_shift_in, lfsr_shift_out, lfsr_msb;
  logic          accept;

  assign accept = ival & ordy;

  bch_enc_lfsr #(
    .R (R),
    .G (G_LOW)
  ) u_lfsr (
    .clk       (iclk),
    .rst_n     (ireset),
    .ena       (iclkena),
    .load      (lfsr_load),
    .shift_in  (lfsr_shift_in),
    .shift_out (lfsr_shift_out),
    .din       (idat),
    .msb       (lfsr_msb)
  );

  // Next-state, LFSR control and registered-output values
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ordy_nxt       = ordy;
    osop_nxt       = 1'b0;
    oval_nxt       = 1'b0;
    oeop_nxt       = 1'b0;
    odat_nxt       = 1'b0;
    lfsr_load      = 1'b0;
    lfsr_shift_in  = 1'b0;
    lfsr_shift_out = 1'b0;
    case (state)
      ST_IDLE, ST_DATA: begin
        // In IDLE only a frame start is accepted; in DATA isop restarts the frame
        if (accept && (isop || state == ST_DATA)) begin
          oval_nxt      = 1'b1;
          odat_nxt      = idat;
          osop_nxt      = isop;
          lfsr_load     = isop;
          lfsr_shift_in = !isop;
          state_nxt     = ST_DATA;
          if (ieop) begin
            state_nxt = ST_PARITY;
            cnt_nxt   = CW'(R - 1);
            ordy_nxt  = 1'b0;
          end
        end
      end
      ST_PARITY: begin
        oval_nxt       = 1'b1;
        odat_nxt       = lfsr_msb;
        lfsr_shift_out = 1'b1;
        cnt_nxt        = cnt - CW'(1);
        if (cnt == '0) begin
          oeop_nxt  = 1'b1;
          state_nxt = ST_IDLE;
          ordy_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        ordy_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ordy  <= 1'b1;
      osop  <= 1'b0;
      oval  <= 1'b0;
      oeop  <= 1'b0;
      odat  <= 1'b0;
    end else if (iclkena) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ordy  <= ordy_nxt;
      osop  <= osop_nxt;
      oval  <= oval_nxt;
      oeop  <= oeop_nxt;
      odat  <= odat_nxt;
    end
  end

endmodule

// File: tb/tb_bch_enc.sv
// Directed bench for bch_enc (m=4, n=15, d=7, g=0x537, r=10).
module tb_bch_enc;

  logic iclk    = 1'b0;
  logic ireset  = 1'b1;
  logic iclkena = 1'b1;
  logic isop    = 1'b0;
  logic ival    = 1'b0;
  logic ieop    = 1'b0;
  logic idat    = 1'b0;
  logic ordy, osop, oval, oeop, odat;

  int n_assert = 0;
  int n_fail   = 0;

  int          sent, got, sop_pos, eop_pos;
  logic [14:0] cw_obs;
  logic [4:0]  sdata;
  logic        en, bub, v;

  bch_enc dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .isop    (isop),
    .ival    (ival),
    .ieop    (ieop),
    .idat    (idat),
    .ordy    (ordy),
    .osop    (osop),
    .oval    (oval),
    .oeop    (oeop),
    .odat    (odat)
  );

  always #5 iclk = ~iclk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic sop, input logic val,
                      input logic eop, input logic dat);
    iclkena = e;
    isop    = sop;
    ival    = val;
    ieop    = eop;
    idat    = dat;
    @(posedge iclk);
    #1;
  endtask

  // One 5-bit frame plus its 10 parity cycles; noise drives ival/isop/ieop during parity
  task automatic run_frame(input string tag, input logic [4:0] data,
                           input logic [14:0] cw, input logic noise);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, i == 0, 1'b1, i == 4, data[4-i]);
      chk1($sformatf("%s_d%0d_odat", tag, i), odat, cw[14-i]);
      chk1($sformatf("%s_d%0d_oval", tag, i), oval, 1'b1);
      chk1($sformatf("%s_d%0d_osop", tag, i), osop, i == 0);
      chk1($sformatf("%s_d%0d_oeop", tag, i), oeop, 1'b0);
      chk1($sformatf("%s_d%0d_ordy", tag, i), ordy, i != 4);
    end
    for (int j = 0; j < 10; j++) begin
      tick(1'b1, noise, noise, noise, noise & 1'($urandom_range(0, 1)));
      chk1($sformatf("%s_p%0d_odat", tag, j), odat, cw[9-j]);
      chk1($sformatf("%s_p%0d_oval", tag, j), oval, 1'b1);
      chk1($sformatf("%s_p%0d_osop", tag, j), osop, 1'b0);
      chk1($sformatf("%s_p%0d_oeop", tag, j), oeop, j == 9);
      chk1($sformatf("%s_p%0d_ordy", tag, j), ordy, j == 9);
    end
  endtask

  initial begin
    // Asynchronous reset values
    #2 ireset = 1'b0;
    #1;
    chk1("rst_ordy", ordy, 1'b1);
    chk1("rst_osop", osop, 1'b0);
    chk1("rst_oval", oval, 1'b0);
    chk1("rst_oeop", oeop, 1'b0);
    chk1("rst_odat", odat, 1'b0);
    repeat (2) @(posedge iclk);
    @(negedge iclk);
    ireset = 1'b1;

    // Single frames; parities are hand-reduced x^k mod g remainders
    run_frame("f00001", 5'b00001, {5'b00001, 10'h137}, 1'b0);
    run_frame("f11111", 5'b11111, {5'b11111, 10'h3FF}, 1'b0);
    run_frame("f00000", 5'b00000, {5'b00000, 10'h000}, 1'b0);

    // Back-to-back frames with no idle cycle between them
    run_frame("b2b_a", 5'b10110, {5'b10110, 10'h11E}, 1'b0);
    run_frame("b2b_b", 5'b01011, {5'b01011, 10'h08F}, 1'b0);

    // Random clock-enable stalls and ival bubbles inside DATA
    sdata   = 5'b10110;
    sent    = 0;
    got     = 0;
    sop_pos = -1;
    eop_pos = -1;
    cw_obs  = '0;
    for (int c = 0; c < 400 && got < 15; c++) begin
      en  = ($urandom_range(0, 2) != 0);
      bub = ($urandom_range(0, 3) == 0);
      v   = (sent < 5) && !bub;
      tick(en, v && sent == 0, v, v && sent == 4, v ? sdata[4-sent] : 1'b0);
      if (en && v) sent++;
      if (en && oval) begin
        cw_obs = {cw_obs[13:0], odat};
        if (osop) sop_pos = got;
        if (oeop) eop_pos = got;
        got++;
      end
    end
    chkw("stall_bits", got, 15);
    chkw("stall_cw", int'(cw_obs), int'({5'b10110, 10'h11E}));
    chkw("stall_sop_pos", sop_pos, 0);
    chkw("stall_eop_pos", eop_pos, 14);

    // Restart after 3 bits; new frame's parity only, noise ignored during parity
    sdata = 5'b00101;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, i == 0, 1'b1, 1'b0, sdata[2-i]);
      chk1($sformatf("pre_d%0d_odat", i), odat, sdata[2-i]);
      chk1($sformatf("pre_d%0d_osop", i), osop, i == 0);
    end
    run_frame("restart", 5'b01011, {5'b01011, 10'h08F}, 1'b1);

    // Asynchronous reset in the middle of parity output
    for (int i = 0; i < 5; i++) tick(1'b1, i == 0, 1'b1, i == 4, 1'b1);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("midpar_odat_before", odat, 1'b1);
    #2 ireset = 1'b0;
    #1;
    chk1("midrst_ordy", ordy, 1'b1);
    chk1("midrst_osop", osop, 1'b0);
    chk1("midrst_oval", oval, 1'b0);
    chk1("midrst_oeop", oeop, 1'b0);
    chk1("midrst_odat", odat, 1'b0);
    @(negedge iclk);
    ireset = 1'b1;

    // IDLE ignores data without isop
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk1("idle_nosop_oval", oval, 1'b0);
    chk1("idle_nosop_ordy", ordy, 1'b1);

    run_frame("after_rst", 5'b10000, {5'b10000, 10'h29B}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
